// File: rtl/oq_pkt_arbiter_pkg.sv
// oq_pkt_arbiter_pkg: shared FSM encoding and byte-to-bit width helpers
package oq_pkt_arbiter_pkg;
  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;
  localparam int BITS_PER_BYTE = 8;
  function automatic int bytes_to_bits(input int n);
    return n * BITS_PER_BYTE;
  endfunction
endpackage

// File: rtl/oq_pkt_arbiter_rr_select.sv
// rr_select: combinational round-robin pick of the first request after last
module rr_select
  import oq_pkt_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 5,
  parameter int IW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IW-1:0]        last,
  output logic                 valid,
  output logic [IW-1:0]        idx
);
  logic [IW-1:0] c;
  // scan farthest-first so the nearest candidate after last wins
  always_comb begin
    valid = 1'b0;
    idx = '0;
    c = '0;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      c = IW'((int'(last) + i) % NUM_PORTS);
      if (req[c]) begin
        valid = 1'b1;
        idx = c;
      end
    end
  end
endmodule

// File: rtl/oq_pkt_arbiter.sv
// oq_pkt_arbiter: packet-granular round-robin AXI-Stream N:1 arbiter with per-port packet counters
module oq_pkt_arbiter
  import oq_pkt_arbiter_pkg::*;
#(
  parameter int NUM_PORTS   = 5,
  parameter int TDATA_WIDTH = 32,
  parameter int TSTRB_WIDTH = TDATA_WIDTH / 8,
  parameter int TUSER_WIDTH = 16,
  parameter int CNT_WIDTH   = 32,
  localparam int DW = bytes_to_bits(TDATA_WIDTH),
  localparam int SW = bytes_to_bits(TSTRB_WIDTH),
  localparam int UW = bytes_to_bits(TUSER_WIDTH)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_PORTS-1:0]           port_en,
  input  logic [NUM_PORTS-1:0]           s_tvalid,
  output logic [NUM_PORTS-1:0]           s_tready,
  input  logic [NUM_PORTS-1:0]           s_tlast,
  input  logic [NUM_PORTS*DW-1:0]        s_tdata,
  input  logic [NUM_PORTS*SW-1:0]        s_tstrb,
  input  logic [NUM_PORTS*UW-1:0]        s_tuser,
  output logic                           m_tvalid,
  input  logic                           m_tready,
  output logic [DW-1:0]                  m_tdata,
  output logic [SW-1:0]                  m_tstrb,
  output logic [UW-1:0]                  m_tuser,
  output logic                           m_tlast,
  output logic [NUM_PORTS-1:0]           grant,
  output logic [NUM_PORTS*CNT_WIDTH-1:0] pkt_cnt
);
  localparam int IW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
  state_t state, state_nx;
  logic [IW-1:0] sel, last_grant, pick;
  logic pick_valid, xfer, beat, eop;
  logic [CNT_WIDTH-1:0] cnt [NUM_PORTS];
  rr_select #(.NUM_PORTS(NUM_PORTS), .IW(IW)) u_rr (
    .req(s_tvalid & port_en),
    .last(last_grant),
    .valid(pick_valid),
    .idx(pick)
  );
  // outputs are forced quiet while reset is held, even mid-packet
  assign xfer = state == XFER && !reset;
  assign m_tvalid = xfer && s_tvalid[sel];
  assign m_tdata = s_tdata[sel*DW +: DW];
  assign m_tstrb = s_tstrb[sel*SW +: SW];
  assign m_tuser = s_tuser[sel*UW +: UW];
  assign m_tlast = s_tlast[sel];
  assign s_tready = xfer ? NUM_PORTS'(m_tready) << sel : '0;
  assign beat = m_tvalid && m_tready;
  assign eop = beat && m_tlast;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (pick_valid ? XFER : IDLE) : (eop ? IDLE : XFER);
  end
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk)
    if (reset) begin
      sel <= '0;
      grant <= '0;
      last_grant <= IW'(NUM_PORTS - 1);
      for (int k = 0; k < NUM_PORTS; k++) cnt[k] <= '0;
    end else begin
      if (state == IDLE && pick_valid) begin
        sel <= pick;
        grant <= NUM_PORTS'(1) << pick;
      end
      if (eop) begin
        last_grant <= sel;
        grant <= '0;
        cnt[sel] <= cnt[sel] + CNT_WIDTH'(1);
      end
    end
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt
    assign pkt_cnt[g*CNT_WIDTH +: CNT_WIDTH] = cnt[g];
  end
endmodule

// File: tb/tb_oq_pkt_arbiter.sv
// tb_oq_pkt_arbiter: table vectors, directed packet scenarios and randomized traffic vs a packet-level model
module tb_oq_pkt_arbiter;
  localparam int NP = 5, CW = 4;
  typedef struct { logic [31:0] d; logic [7:0] s; logic [15:0] u; logic l; } beat_t;
  typedef struct { logic [NP-1:0] v; logic [NP-1:0] e; logic [NP-1:0] g; } vec_t;
  logic clk = 0, reset = 1, m_tready = 1;
  logic [NP-1:0] port_en = '1, s_tvalid = '0, s_tready, s_tlast = '0, grant;
  logic [NP*32-1:0] s_tdata = '0;
  logic [NP*8-1:0] s_tstrb = '0;
  logic [NP*16-1:0] s_tuser = '0;
  logic m_tvalid, m_tlast;
  logic [31:0] m_tdata;
  logic [7:0] m_tstrb;
  logic [15:0] m_tuser;
  logic [NP*CW-1:0] pkt_cnt;
  oq_pkt_arbiter #(.NUM_PORTS(NP), .TDATA_WIDTH(4), .TSTRB_WIDTH(1), .TUSER_WIDTH(2), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .port_en(port_en),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .s_tdata(s_tdata), .s_tstrb(s_tstrb), .s_tuser(s_tuser),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
    .m_tstrb(m_tstrb), .m_tuser(m_tuser), .m_tlast(m_tlast),
    .grant(grant), .pkt_cnt(pkt_cnt)
  );
  always #5 clk = ~clk;
  beat_t q[NP][$];
  int nseq[NP], eseq[NP];
  int cur = -1, lastg = NP - 1, vprob = 100, rmode = 0;
  logic [NP*CW-1:0] ecnt = '0;
  logic [NP-1:0] prev_g = '0;
  int gseq[$];
  int passed = 0, total = 0;
  vec_t tbl[8];
  function automatic void chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %0h expected %0h", n, a, e);
  endfunction
  function automatic int rr(input logic [NP-1:0] r, input int from);
    for (int i = 1; i <= NP; i++) if (r[(from + i) % NP]) return (from + i) % NP;
    return -1;
  endfunction
  function automatic logic busy();
    for (int k = 0; k < NP; k++) if (q[k].size() != 0) return 1'b1;
    return cur >= 0;
  endfunction
  task automatic push(input int k, input int len);
    for (int i = 0; i < len; i++) begin
      q[k].push_back('{d: (32'(k) << 24) | 32'(nseq[k]), s: 8'($urandom), u: 16'($urandom), l: i == len - 1});
      nseq[k]++;
    end
  endtask
  // one clock: drive sources, compare at negedge, advance the model
  task automatic cyc();
    logic [NP-1:0] etr;
    logic etv;
    beat_t b;
    for (int k = 0; k < NP; k++) begin
      if (q[k].size() != 0) b = q[k][0];
      else b = '{d: 32'hdead_0000, s: 8'h0, u: 16'h0, l: 1'b0};
      s_tvalid[k] = q[k].size() != 0 && $urandom_range(99) < vprob;
      s_tdata[k*32 +: 32] = b.d;
      s_tstrb[k*8 +: 8] = b.s;
      s_tuser[k*16 +: 16] = b.u;
      s_tlast[k] = b.l;
    end
    m_tready = rmode == 0 ? 1'b1 : rmode == 2 ? ~m_tready : 1'($urandom_range(1));
    @(negedge clk);
    etv = 1'b0;
    etr = '0;
    if (!reset && cur >= 0) begin
      etv = s_tvalid[cur];
      etr = NP'(m_tready) << cur;
    end
    chk("m_tvalid", m_tvalid, etv);
    chk("s_tready", s_tready, etr);
    if (!reset) begin
      chk("grant", grant, cur >= 0 ? NP'(1) << cur : NP'(0));
      chk("pkt_cnt", pkt_cnt, ecnt);
      if (grant != 0 && prev_g == 0)
        for (int k = 0; k < NP; k++) if (grant[k]) gseq.push_back(k);
      prev_g = grant;
    end else prev_g = '0;
    if (etv) begin
      b = q[cur][0];
      chk("m_tdata", m_tdata, (32'(cur) << 24) | 32'(eseq[cur]));
      chk("m_tstrb", m_tstrb, b.s);
      chk("m_tuser", m_tuser, b.u);
      chk("m_tlast", m_tlast, b.l);
    end
    if (reset) begin
      cur = -1;
      lastg = NP - 1;
      ecnt = '0;
    end else if (cur < 0) cur = rr(s_tvalid & port_en, lastg);
    else if (etv && m_tready) begin
      b = q[cur].pop_front();
      eseq[cur]++;
      if (b.l) begin
        ecnt[cur*CW +: CW] += 1;
        lastg = cur;
        cur = -1;
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1;
    cyc();
    cyc();
    reset = 0;
  endtask
  task automatic clean();
    for (int k = 0; k < NP; k++) begin
      q[k].delete();
      eseq[k] = nseq[k];
    end
    gseq.delete();
    port_en = '1;
    vprob = 100;
    rmode = 0;
    do_reset();
  endtask
  task automatic drain(input int maxc);
    int n = 0;
    while (busy() && n < maxc) begin
      cyc();
      n++;
    end
    chk("drain timeout", 64'(busy()), 64'(0));
  endtask
  initial begin
    tbl = '{'{5'b00101, 5'b11111, 5'b00001}, '{5'b10100, 5'b11111, 5'b00100},
            '{5'b10100, 5'b11011, 5'b10000}, '{5'b00000, 5'b11111, 5'b00000},
            '{5'b11111, 5'b00000, 5'b00000}, '{5'b10000, 5'b11111, 5'b10000},
            '{5'b11110, 5'b11100, 5'b00100}, '{5'b01000, 5'b01000, 5'b01000}};
    for (int i = 0; i < 8; i++) begin
      do_reset();
      s_tvalid = tbl[i].v;
      port_en = tbl[i].e;
      s_tlast = '1;
      m_tready = 0;
      @(negedge clk);
      chk("idle m_tvalid", m_tvalid, 0);
      chk("idle grant", grant, 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk($sformatf("tbl%0d grant", i), grant, tbl[i].g);
      @(posedge clk);
      #1;
    end
    clean();
    push(0, 3);
    push(2, 3);
    drain(30);
    chk("t38 npkts", gseq.size(), 2);
    chk("t38 first", gseq[0], 0);
    chk("t38 second", gseq[1], 2);
    chk("t38 cnt", pkt_cnt, 20'h00101);
    clean();
    for (int r = 0; r < 3; r++) for (int k = 0; k < NP; k++) push(k, 1);
    drain(100);
    chk("t39 npkts", gseq.size(), 15);
    for (int i = 0; i < 15; i++) chk($sformatf("t39 order%0d", i), gseq[i], i % NP);
    clean();
    m_tready = 0;
    rmode = 2;
    push(1, 10);
    drain(60);
    chk("t40 cnt", pkt_cnt, 20'h00010);
    clean();
    push(3, 8);
    cyc();
    push(0, 2); push(0, 2); push(1, 2); push(1, 2); push(3, 2);
    repeat (3) cyc();
    port_en = 5'b10111;
    cyc();
    repeat (30) cyc();
    chk("t41 first", gseq[0], 3);
    chk("t41 npkts", gseq.size(), 5);
    for (int i = 1; i < gseq.size(); i++) chk("t41 no port3", 64'(gseq[i] == 3), 0);
    chk("t41 cnt", pkt_cnt, 20'h01022);
    clean();
    push(1, 10);
    repeat (5) cyc();
    reset = 1;
    cyc();
    reset = 0;
    push(0, 2);
    gseq.delete();
    drain(40);
    chk("t42 first", gseq[0], 0);
    chk("t42 cnt", pkt_cnt, 20'h00011);
    clean();
    push(2, 1);
    for (int i = 0; i < 16; i++) push(4, 1 + $urandom_range(2));
    drain(200);
    chk("t43 cnt", pkt_cnt, 20'h00100);
    clean();
    vprob = 70;
    rmode = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(9) == 0) begin
        int k = $urandom_range(NP - 1);
        if (q[k].size() < 20) push(k, 1 + $urandom_range(5));
      end
      if ($urandom_range(99) == 0) port_en = NP'($urandom);
      reset = $urandom_range(999) == 0;
      cyc();
      reset = 0;
    end
    port_en = '1;
    vprob = 100;
    rmode = 0;
    drain(1000);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/oq_pkt_arbiter.md
OQ_PKT_ARBITER -- requirements
Module: oq_pkt_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 5, number of AXI-Stream slave ports.
REQ-002 Parameter TDATA_WIDTH, default 32, tdata width in bytes; the bus is 8*TDATA_WIDTH bits.
REQ-003 Parameter TSTRB_WIDTH, default TDATA_WIDTH/8, tstrb width in bytes; the bus is 8*TSTRB_WIDTH bits.
REQ-004 Parameter TUSER_WIDTH, default 16, tuser width in bytes; the bus is 8*TUSER_WIDTH bits.
REQ-005 Parameter CNT_WIDTH, default 32, width of each per-port packet counter.
REQ-006 Port clk, input, 1 bit: clock; all logic is on the rising edge.
REQ-007 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 Port port_en, input, NUM_PORTS bits: per-port arbitration enable mask.
REQ-009 Ports s_tvalid/s_tready/s_tlast, NUM_PORTS bits each: slave handshake and last flag; s_tready is an output, the others are inputs.
REQ-010 Ports s_tdata, s_tstrb, s_tuser, inputs, NUM_PORTS times the bus width: flattened slave payloads; port k occupies slice k.
REQ-011 Ports m_tvalid/m_tdata/m_tstrb/m_tuser/m_tlast (outputs) and m_tready (input): master AXI-Stream port.
REQ-012 Port grant, output, NUM_PORTS bits: one-hot currently granted port, all zero when idle.
REQ-013 Port pkt_cnt, output, NUM_PORTS*CNT_WIDTH bits: packets forwarded per port.

Function
REQ-014 The FSM SHALL have two states: IDLE and XFER.
REQ-015 IDLE: the request vector SHALL be s_tvalid AND port_en.
REQ-016 IDLE: if any request is set, the arbiter SHALL choose the first requesting port, searching round-robin from last_grant+1 modulo NUM_PORTS.
REQ-017 IDLE: the arbiter SHALL register the chosen port and the grant, then enter XFER on the next edge.
REQ-018 IDLE: m_tvalid SHALL be 0 and every s_tready SHALL be 0.
REQ-019 XFER: m_tvalid/m_tdata/m_tstrb/m_tuser/m_tlast SHALL combinationally equal the granted port's inputs.
REQ-020 XFER: s_tready[granted] SHALL equal m_tready, and every other s_tready SHALL be 0.
REQ-021 XFER: a beat SHALL transfer only when m_tvalid and m_tready are both 1; no beat SHALL be dropped or duplicated.
REQ-022 XFER: a beat transfer with m_tlast=1 SHALL return the FSM to IDLE, set last_grant to the granted port, and increment pkt_cnt[granted] by 1.
REQ-023 The arbitration bubble SHALL be exactly 1 cycle of m_tvalid=0 between packets.
REQ-024 The grant SHALL hold for a whole packet; deasserting port_en mid-packet SHALL NOT interrupt the packet and SHALL only exclude the port from the next arbitration.
REQ-025 XFER with the granted s_tvalid=0 (source stall) SHALL hold the state with m_tvalid=0.
REQ-026 Wrap-around: pkt_cnt SHALL wrap from 2^CNT_WIDTH-1 to 0 without affecting other counters.
REQ-027 Wrap-around: the round-robin search SHALL wrap from port NUM_PORTS-1 to port 0.
REQ-028 IDLE with no requests SHALL hold the state with grant=0.
REQ-029 A single-beat packet (tlast on the first beat) SHALL be fully supported.

Reset
REQ-030 Reset SHALL put the FSM in IDLE and set grant=0.
REQ-031 Reset SHALL set last_grant=NUM_PORTS-1, so port 0 has first priority.
REQ-032 Reset SHALL clear every pkt_cnt to 0.
REQ-033 Outputs during and after reset SHALL be m_tvalid=0 and s_tready=0.
REQ-034 Reset mid-packet SHALL abandon the packet immediately; no recovery of the partial packet is required.

Structure
REQ-035 A shared package SHALL hold the state encoding (IDLE=0, XFER=1) and the byte-to-bit width helper constants.
REQ-036 The round-robin search SHALL be a sub-module rr_select: inputs req[NUM_PORTS] and last[log2]; outputs valid and idx; purely combinational.
REQ-037 The FSM, counters and muxes SHALL remain in oq_pkt_arbiter.

Verification
REQ-038 Ports 0 and 2 each request a 3-beat packet at once after reset -> port 0 is forwarded first (3 beats), then 1 idle cycle, then port 2; pkt_cnt[0]=1 and pkt_cnt[2]=1.
REQ-039 All 5 ports continuously request 1-beat packets -> grant order is 0,1,2,3,4,0,...; exactly 1 bubble cycle between packets.
REQ-040 m_tready is toggled 1,0,1,0 during a 10-beat packet from port 1 -> all 10 beats arrive in order with tdata unchanged; s_tready[1] mirrors m_tready.
REQ-041 port_en[3] goes to 0 during the 4th beat of a port-3 packet -> the packet completes; port 3 is not granted afterwards while other ports request.
REQ-042 Reset is asserted on beat 5 of a 10-beat packet -> the next cycle shows grant=0, m_tvalid=0 and all pkt_cnt=0; the next arbitration starts at port 0.
REQ-043 With CNT_WIDTH=4, 16 packets are sent on port 4 -> pkt_cnt[4] wraps to 0; the other counters are unchanged.
